demux5_capture: RTL and testbench
=================================

Name: demux5_capture

Overview:
- Receiving end of the shared 5-bit select-bus used on the vending-machine datapath. A 2:1 mux drives one tagged bus; this block steers each word back to one of two registered destination channels, A or B.
- Each channel holds its word with a valid/ack handshake toward its consumer, such as the display driver or change logic.
- Raises a one-cycle pair pulse once both channels have captured fresh words.
- Sits between the shared bus and the two consumers, one clock domain.

Parameters:
- WIDTH, 5, data width per channel.
- CNT_W, 8, width of the optional overrun counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  shared bus data.
- din_sel  input  1  destination tag: 0 selects channel A, 1 selects channel B.
- din_valid  input  1  bus word present this cycle.
- din_ready  output  1  the selected channel can accept the word this cycle (combinational).
- a_data  output  WIDTH  channel A held word.
- a_valid  output  1  channel A word pending.
- a_ack  input  1  consumer A takes the word.
- b_data  output  WIDTH  channel B held word.
- b_valid  output  1  channel B word pending.
- b_ack  input  1  consumer B takes the word.
- pair_done  output  1  one-cycle pulse when both channels have captured since the last pair_done.
- overrun_cnt  output  CNT_W  dropped-word count; present only with the macro.

Behaviour:
- Reset (synchronous, active-high, clk edge) clears: a_data=0, b_data=0, a_valid=0, b_valid=0, pair_done=0, overrun_cnt=0, and both internal got flags (got_a, got_b). A reset mid-transfer discards held words; a word presented in the reset cycle is not captured.
- din_ready = din_sel ? (~b_valid | b_ack) : (~a_valid | a_ack). Purely combinational, no dependence on din_valid.
- Capture: when din_valid & din_ready, the selected channel loads din on the next edge and its valid goes to 1. Latency is 1 cycle from bus to x_valid.
- Ack: x_ack while x_valid=1 clears x_valid on the next edge. x_ack while x_valid=0 is ignored. x_data holds its value after the ack and is not cleared.
- Ack and capture on the same channel in the same cycle: the new word loads and x_valid stays 1. The word is not lost and no bubble is inserted.
- The unselected channel is unaffected by the bus in any cycle.
- Per-channel state machine (2 states):
  - EMPTY to FULL on capture.
  - FULL to EMPTY on ack without capture.
  - FULL to FULL on ack with capture.
  - FULL to FULL with no ack while a bus word targets the channel: that word is dropped (din_ready=0).
- Pair tracking:
  - got_a / got_b set on a capture into A / B.
  - When both are set, or would be set by this cycle's capture, pair_done=1 on the next cycle and both flags clear in that same cycle.
  - A capture to A while got_a is already set keeps the flag set (no double count).
- Drop rule: din_valid & ~din_ready. The upstream source treats ready as mandatory; a dropped word has no effect on data, valid, or the got flags.

Optional Feature:
- Macro DEMUX5_OVERRUN_CNT_EN.
- Defined:
  - overrun_cnt increments by 1 on each dropped word.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Cleared only by reset.
- Undefined:
  - The port and the counter are absent.
  - Dropped words are silently discarded.
  - All other behaviour is identical.

Decomposition:
- Shared package/include file (demux5_pkg): WIDTH default, CNT_W default, state encodings CH_EMPTY=1'b0 and CH_FULL=1'b1, channel tag constants SEL_A=0 and SEL_B=1.
- One natural sub-module: demux5_chan_reg, a single channel holding register with load/ack/valid logic. It is instantiated twice, for A and B; top-level steering, pair tracking, and the counter stay in demux5_capture.

Test Plan:
- Reset: assert reset for 2 cycles with din_valid=1, din=5'h1F. Required: all outputs 0 and nothing captured; after release, din_ready=1.
- Basic steer: din=5'h0A, sel=0, valid=1 for one cycle. Required: next cycle a_data=5'h0A, a_valid=1, b_valid=0. Then din=5'h15, sel=1. Required: b_data=5'h15, b_valid=1, and pair_done pulses exactly 1 cycle.
- Backpressure: A full with no ack, send 5'h03 to A. Required: din_ready=0, a_data stays 5'h0A; with the macro defined, overrun_cnt=1.
- Simultaneous ack and capture: A holds 5'h0A, a_ack=1, and 5'h07 is sent to A in the same cycle. Required: din_ready=1, next a_data=5'h07, a_valid stays 1.
- Saturation (macro on, CNT_W=2): force 5 drops. Required: overrun_cnt ends at 3.
- Reset mid-operation: A and B full, got_a set, assert reset. Required: valids and pair_done are 0; a later single capture into B does not pulse pair_done.

Source files
------------

// File: rtl/demux5_pkg.sv
// demux5_pkg: shared constants and types for the demux5 select-bus capture block.
package demux5_pkg;

    localparam int unsigned WIDTH_DEF = 5;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux5_capture_if.sv
// demux5_capture_if: shared select-bus plus the two channel handshakes.
// master = bus source / consumers side, slave = the capture block.
interface demux5_capture_if
    import demux5_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] din;
    logic             din_sel;
    logic             din_valid;
    logic             din_ready;

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ack;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ack;

    modport master (
        output din, din_sel, din_valid, a_ack, b_ack,
        input  din_ready, a_data, a_valid, b_data, b_valid
    );

    modport slave (
        input  din, din_sel, din_valid, a_ack, b_ack,
        output din_ready, a_data, a_valid, b_data, b_valid
    );

endinterface

// File: rtl/demux5_chan_reg.sv
// demux5_chan_reg: one destination channel holding register with valid/ack.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   CH_EMPTY | no word pending, any targeted bus word loads
//   CH_FULL  | word pending for the consumer; a new word only
//            | loads in the same cycle the consumer acks
module demux5_chan_reg
    import demux5_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req,
    input  logic [WIDTH-1:0] din,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             ready,
    output logic             load
);

    ch_state_t state;
    ch_state_t state_nxt;

    assign valid = (state == CH_FULL);
    // An ack frees the slot in the same cycle, so back-to-back words never bubble.
    assign ready = (state == CH_EMPTY) | ack;
    assign load  = load_req & ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CH_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: load wins over ack so a simultaneous ack+load stays full.
    always_comb begin
        state_nxt = state;
        case (state)
            CH_EMPTY: begin
                if (load) begin
                    state_nxt = CH_FULL;
                end
            end
            CH_FULL: begin
                if (load) begin
                    state_nxt = CH_FULL;
                end else if (ack) begin
                    state_nxt = CH_EMPTY;
                end
            end
            default: state_nxt = CH_EMPTY;
        endcase
    end

    // Held word; kept after ack so the consumer can still look at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end
    end

endmodule

// File: rtl/demux5_capture.sv
// demux5_capture: steers tagged words from the shared select-bus into
// channel A or B, and pulses pair_done once both have captured.
// Optional overrun counter enabled by defining DEMUX5_OVERRUN_CNT_EN.
module demux5_capture
    import demux5_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    demux5_capture_if.slave  bus,
    output logic             pair_done
`ifdef DEMUX5_OVERRUN_CNT_EN
    ,
    output logic [CNT_W-1:0] overrun_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("demux5_capture: WIDTH and CNT_W must be at least 1");
    end

    logic a_ready;
    logic b_ready;
    logic a_load;
    logic b_load;
    logic got_a;
    logic got_b;
    logic got_a_nxt;
    logic got_b_nxt;
    logic drop;

    demux5_chan_reg #(.WIDTH(WIDTH)) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .load_req (bus.din_valid & (bus.din_sel == SEL_A)),
        .din      (bus.din),
        .ack      (bus.a_ack),
        .data     (bus.a_data),
        .valid    (bus.a_valid),
        .ready    (a_ready),
        .load     (a_load)
    );

    demux5_chan_reg #(.WIDTH(WIDTH)) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .load_req (bus.din_valid & (bus.din_sel == SEL_B)),
        .din      (bus.din),
        .ack      (bus.b_ack),
        .data     (bus.b_data),
        .valid    (bus.b_valid),
        .ready    (b_ready),
        .load     (b_load)
    );

    assign bus.din_ready = (bus.din_sel == SEL_B) ? b_ready : a_ready;
    assign drop          = bus.din_valid & ~bus.din_ready;

    // Flags as they would stand after this cycle's capture.
    always_comb begin
        got_a_nxt = got_a | a_load;
        got_b_nxt = got_b | b_load;
    end

    // Pair tracking: fire once both flags would be set, then start over.
    always_ff @(posedge clk) begin
        if (reset) begin
            got_a     <= 1'b0;
            got_b     <= 1'b0;
            pair_done <= 1'b0;
        end else if (got_a_nxt & got_b_nxt) begin
            got_a     <= 1'b0;
            got_b     <= 1'b0;
            pair_done <= 1'b1;
        end else begin
            got_a     <= got_a_nxt;
            got_b     <= got_b_nxt;
            pair_done <= 1'b0;
        end
    end

`ifdef DEMUX5_OVERRUN_CNT_EN
    // Dropped-word counter, saturating so a long stall never reads as few drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt <= '0;
        end else if (drop && (overrun_cnt != {CNT_W{1'b1}})) begin
            overrun_cnt <= overrun_cnt + 1'b1;
        end
    end
`else
    logic drop_unused;
    assign drop_unused = drop;
`endif

endmodule

// File: tb/tb_demux5_capture.sv
// tb_demux5_capture: directed vector table, hand sequences for reset and
// saturation corners, then random traffic against a behavioural model.
module tb_demux5_capture;
    import demux5_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic pair_done;

    always #5 clk = ~clk;

    demux5_capture_if #(.WIDTH(5)) bus ();

`ifdef DEMUX5_OVERRUN_CNT_EN
    localparam int CW = 2;
    logic [CW-1:0] overrun_cnt;
    demux5_capture #(.WIDTH(5), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .pair_done   (pair_done),
        .overrun_cnt (overrun_cnt)
    );
`else
    demux5_capture #(.WIDTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pair_done (pair_done)
    );
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] din;
        logic       sel;
        logic       valid;
        logic       a_ack;
        logic       b_ack;
        logic       e_ready;
        logic       e_a_valid;
        logic [4:0] e_a_data;
        logic       e_b_valid;
        logic [4:0] e_b_data;
        logic       e_pair;
    } vec_t;

    vec_t vecs[10];

    // behavioural model state
    logic       ma_v, mb_v, mga, mgb, m_pair;
    logic [4:0] ma_d, mb_d;
    int         m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] d, input logic s, input logic v,
                         input logic aa, input logic ba);
        bus.din       = d;
        bus.din_sel   = s;
        bus.din_valid = v;
        bus.a_ack     = aa;
        bus.b_ack     = ba;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ma_v = 0; mb_v = 0; mga = 0; mgb = 0; m_pair = 0;
        ma_d = '0; mb_d = '0; m_cnt = 0;
    endtask

    // Expected din_ready from the model's view of the slots.
    function automatic logic model_ready(input logic s, input logic aa, input logic ba);
        if (s) return !mb_v || ba;
        return !ma_v || aa;
    endfunction

    task automatic model_step(input logic rst, input logic [4:0] d, input logic s,
                              input logic v, input logic aa, input logic ba);
        logic rdy;
        logic cap;
        if (rst) begin
            model_reset();
            return;
        end
        rdy    = model_ready(s, aa, ba);
        cap    = v && rdy;
        m_pair = 0;
        if (cap && !s) begin ma_v = 1; ma_d = d; end
        else if (aa) ma_v = 0;
        if (cap && s) begin mb_v = 1; mb_d = d; end
        else if (ba) mb_v = 0;
        if (cap) begin
            if (s) mgb = 1;
            else   mga = 1;
        end
        if (mga && mgb) begin
            m_pair = 1; mga = 0; mgb = 0;
        end
        if (v && !rdy && m_cnt < 3) m_cnt++;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".a_valid"}, 32'(bus.a_valid), 32'(ma_v));
        chk({tag, ".a_data"},  32'(bus.a_data),  32'(ma_d));
        chk({tag, ".b_valid"}, 32'(bus.b_valid), 32'(mb_v));
        chk({tag, ".b_data"},  32'(bus.b_data),  32'(mb_d));
        chk({tag, ".pair"},    32'(pair_done),   32'(m_pair));
`ifdef DEMUX5_OVERRUN_CNT_EN
        chk({tag, ".overrun"}, 32'(overrun_cnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        vecs[0] = '{5'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h0A, 1'b0, 5'h00, 1'b0};
        vecs[1] = '{5'h15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h0A, 1'b1, 5'h15, 1'b1};
        vecs[2] = '{5'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h0A, 1'b1, 5'h15, 1'b0};
        vecs[3] = '{5'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'h07, 1'b1, 5'h15, 1'b0};
        vecs[4] = '{5'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h07, 1'b1, 5'h15, 1'b0};
        vecs[5] = '{5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'h07, 1'b0, 5'h15, 1'b0};
        vecs[6] = '{5'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'h07, 1'b1, 5'h11, 1'b1};
        vecs[7] = '{5'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'h07, 1'b1, 5'h11, 1'b0};
        vecs[8] = '{5'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'h07, 1'b1, 5'h04, 1'b0};
        vecs[9] = '{5'h09, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h09, 1'b1, 5'h04, 1'b1};

        // Reset held two cycles with a word on the bus: nothing captured.
        reset = 1'b1;
        drive(5'h1F, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst.a_valid", 32'(bus.a_valid), 0);
        chk("rst.b_valid", 32'(bus.b_valid), 0);
        chk("rst.a_data",  32'(bus.a_data),  0);
        chk("rst.b_data",  32'(bus.b_data),  0);
        chk("rst.pair",    32'(pair_done),   0);
`ifdef DEMUX5_OVERRUN_CNT_EN
        chk("rst.overrun", 32'(overrun_cnt), 0);
`endif
        reset = 1'b0;
        drive(5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst.ready_a", 32'(bus.din_ready), 1);
        bus.din_sel = 1'b1;
        #1;
        chk("rst.ready_b", 32'(bus.din_ready), 1);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].din, vecs[i].sel, vecs[i].valid, vecs[i].a_ack, vecs[i].b_ack);
            #1;
            chk($sformatf("vec%0d.ready", i), 32'(bus.din_ready), 32'(vecs[i].e_ready));
            tick();
            chk($sformatf("vec%0d.a_valid", i), 32'(bus.a_valid), 32'(vecs[i].e_a_valid));
            chk($sformatf("vec%0d.a_data", i),  32'(bus.a_data),  32'(vecs[i].e_a_data));
            chk($sformatf("vec%0d.b_valid", i), 32'(bus.b_valid), 32'(vecs[i].e_b_valid));
            chk($sformatf("vec%0d.b_data", i),  32'(bus.b_data),  32'(vecs[i].e_b_data));
            chk($sformatf("vec%0d.pair", i),    32'(pair_done),   32'(vecs[i].e_pair));
`ifdef DEMUX5_OVERRUN_CNT_EN
            if (i == 2) chk("vec2.overrun", 32'(overrun_cnt), 1);
`endif
        end

`ifdef DEMUX5_OVERRUN_CNT_EN
        // Both channels full, five more drops: 2-bit counter pins at 3.
        chk("sat.start", 32'(overrun_cnt), 2);
        for (int i = 0; i < 5; i++) begin
            drive(5'(i), 1'(i % 2), 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("sat.overrun", 32'(overrun_cnt), 3);
        chk("sat.a_data",  32'(bus.a_data),  32'h09);
        chk("sat.b_data",  32'(bus.b_data),  32'h04);
`endif

        // Reset mid-operation with got_a set and both channels full.
        drive(5'h0C, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("mid.a_data", 32'(bus.a_data), 32'h0C);
        chk("mid.pair0",  32'(pair_done),  0);
        reset = 1'b1;
        drive(5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        chk("mid.a_valid", 32'(bus.a_valid), 0);
        chk("mid.b_valid", 32'(bus.b_valid), 0);
        chk("mid.pair1",   32'(pair_done),   0);
        drive(5'h05, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mid.b_cap",  32'(bus.b_valid), 1);
        chk("mid.pair2",  32'(pair_done),   0);
        drive(5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mid.pair3",  32'(pair_done),   0);

        // Random traffic against the model, starting from a clean reset.
        reset = 1'b1;
        repeat (2) tick();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic       r_rst;
            logic [4:0] r_din;
            logic       r_sel, r_v, r_aa, r_ba;
            r_rst = ($urandom_range(0, 63) == 0);
            r_din = 5'($urandom);
            r_sel = 1'($urandom);
            r_v   = ($urandom_range(0, 9) < 7);
            r_aa  = 1'($urandom);
            r_ba  = ($urandom_range(0, 3) == 0);
            reset = r_rst;
            drive(r_din, r_sel, r_v, r_aa, r_ba);
            #1;
            chk($sformatf("rnd%0d.ready", n), 32'(bus.din_ready),
                32'(model_ready(r_sel, r_aa, r_ba)));
            model_step(r_rst, r_din, r_sel, r_v, r_aa, r_ba);
            tick();
            chk_outputs($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
